// File: rtl/mole_memory_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mole_memory_if : hole-select / lifetime inputs and mole outputs    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface mole_memory_if #(
  parameter int CNT_W = 4
);
  logic [CNT_W-1:0] counter;
  logic             sel1;
  logic             sel2;
  logic             sel3;
  logic             sel4;
  logic             o1;
  logic             o2;
  logic             o3;
  logic             o4;

  modport master (
    output counter, sel1, sel2, sel3, sel4,
    input  o1, o2, o3, o4
  );

  modport slave (
    input  counter, sel1, sel2, sel3, sel4,
    output o1, o2, o3, o4
  );
endinterface
`default_nettype wire

// File: rtl/mole_memory.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mole_memory : raises one mole per hole-select rise, for a counted  |
// |               lifetime. Rev 1.0                                    |
// +--------------------------------------------------------------------+
module mole_memory #(
  parameter int CNT_W     = 4,
  parameter int ZERO_LIFE = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  mole_memory_if.slave bus
);
  localparam int              TW        = CNT_W + 1;
  localparam logic [TW-1:0]   ZERO_LOAD = TW'(ZERO_LIFE);

  logic [3:0]    sel;
  logic [3:0]    rise;
  logic [3:0]    win;
  logic [TW-1:0] load;
  logic [3:0]    sel_q;
  logic [TW-1:0] timer_q [4];
  logic [TW-1:0] timer_d [4];

  assign sel  = {bus.sel4, bus.sel3, bus.sel2, bus.sel1};
  assign rise = sel & ~sel_q;
  // Isolate the lowest set bit so simultaneous rises resolve to the lowest hole.
  assign win  = rise & (~rise + 4'd1);
  assign load = (bus.counter == '0) ? ZERO_LOAD : TW'(bus.counter);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      timer_d[i] = timer_q[i];
      if (rise != 4'd0) begin
        timer_d[i] = win[i] ? load : '0;
      end else if (timer_q[i] != '0) begin
        timer_d[i] = timer_q[i] - TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
      for (int i = 0; i < 4; i++) begin
        timer_q[i] <= '0;
      end
    end else begin
      sel_q <= sel;
      for (int i = 0; i < 4; i++) begin
        timer_q[i] <= timer_d[i];
      end
    end
  end

  assign bus.o1 = (timer_q[0] != '0);
  assign bus.o2 = (timer_q[1] != '0);
  assign bus.o3 = (timer_q[2] != '0);
  assign bus.o4 = (timer_q[3] != '0);
endmodule
`default_nettype wire

// File: tb/tb_mole_memory.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mole_memory : scoreboard bench with a single-active-mole model  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mole_memory;
  localparam int CNT_W     = 4;
  localparam int ZERO_LIFE = 16;

  logic clk;
  logic rst_n;

  mole_memory_if #(.CNT_W(CNT_W)) bus ();

  mole_memory #(
    .CNT_W     (CNT_W),
    .ZERO_LIFE (ZERO_LIFE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] exp_q [$];

  // Since a load clears every other slot, only one mole can be up: track it as
  // (which hole, cycles left) rather than four timers.
  logic [3:0] m_prev;
  int         m_cur;
  int         m_rem;

  function automatic logic [3:0] dut_o();
    return {bus.o4, bus.o3, bus.o2, bus.o1};
  endfunction

  task automatic model_reset();
    m_prev = 4'd0;
    m_cur  = 0;
    m_rem  = 0;
  endtask

  task automatic check_now(input string name, input logic [3:0] want);
    logic [3:0] got;
    got = dut_o();
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: o4..o1 got %b want %b at %0t", name, got, want, $time);
    end
  endtask

  // Called at a negedge: drive inputs, advance the model over the coming
  // rising edge, push the expected outputs, then wait for the next negedge.
  task automatic step(input logic [3:0] sel, input logic [3:0] cnt);
    logic [3:0] rise;
    logic [3:0] want;
    bus.sel1    = sel[0];
    bus.sel2    = sel[1];
    bus.sel3    = sel[2];
    bus.sel4    = sel[3];
    bus.counter = cnt;
    rise = sel & ~m_prev;
    if (rise != 4'd0) begin
      for (int k = 3; k >= 0; k--) begin
        if (rise[k]) m_cur = k;
      end
      m_rem = (cnt == 4'd0) ? ZERO_LIFE : int'(cnt);
    end else if (m_rem > 0) begin
      m_rem--;
    end
    m_prev = sel;
    want = (m_rem > 0) ? (4'b0001 << m_cur) : 4'b0000;
    exp_q.push_back(want);
    @(negedge clk);
  endtask

  task automatic repeat_step(input int n, input logic [3:0] sel, input logic [3:0] cnt);
    for (int i = 0; i < n; i++) step(sel, cnt);
  endtask

  // Monitor: every rising edge out of reset consumes one expected vector.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_empty: o4..o1 got %b want <queued value> at %0t", dut_o(), $time);
      end else begin
        check_now("sb_out", exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [3:0] sel_r;
    logic [3:0] cnt_r;
    rst_n       = 1'b0;
    bus.sel1    = 1'b0;
    bus.sel2    = 1'b0;
    bus.sel3    = 1'b0;
    bus.sel4    = 1'b0;
    bus.counter = 4'd0;
    model_reset();
    #1;
    check_now("reset_init", 4'b0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic raise, lifetime 3
    repeat_step(2, 4'b0000, 4'd3);
    repeat_step(5, 4'b0001, 4'd3);
    step(4'b0000, 4'd3);

    // Zero counter means a 16-cycle lifetime
    repeat_step(18, 4'b0100, 4'd0);
    step(4'b0000, 4'd9);

    // Handover from mole 1 to mole 2
    repeat_step(4, 4'b0001, 4'd8);
    repeat_step(7, 4'b0010, 4'd5);
    step(4'b0000, 4'd5);

    // Re-select restarts, held level does not re-raise
    repeat_step(2, 4'b1000, 4'd4);
    step(4'b0000, 4'd4);
    repeat_step(8, 4'b1000, 4'd4);
    step(4'b0000, 4'd4);

    // Counter changes mid-lifetime do not disturb a running mole
    step(4'b0010, 4'd6);
    repeat_step(6, 4'b0010, 4'd1);

    // Multi-hot rise: lowest hole wins
    step(4'b0000, 4'd2);
    repeat_step(4, 4'b0110, 4'd2);
    step(4'b0000, 4'd2);

    // Asynchronous reset mid-cycle with mole 2 up
    step(4'b0000, 4'd7);
    repeat_step(2, 4'b0010, 4'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("reset_async", 4'b0000);
    model_reset();
    bus.sel1 = 1'b1;
    bus.sel2 = 1'b0;
    repeat (2) @(negedge clk);
    check_now("reset_hold", 4'b0000);

    // Reset exit with sel1 already high raises mole 1
    rst_n = 1'b1;
    repeat_step(7, 4'b0001, 4'd5);
    step(4'b0000, 4'd5);

    // Randomised play: mostly one-hot holes, occasional multi-hot, held levels
    sel_r = 4'b0000;
    cnt_r = 4'd0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 6))
          0, 1:    sel_r = 4'b0000;
          2:       sel_r = 4'($urandom_range(0, 15));
          default: sel_r = 4'b0001 << $urandom_range(0, 3);
        endcase
      end
      cnt_r = 4'($urandom_range(0, 15));
      step(sel_r, cnt_r);
    end

    repeat_step(2, 4'b0000, 4'd1);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_drain: %0d entries left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
